// File: rtl/seq_divider32_pkg.sv
// Shared definitions for the sequential restoring divider: sizes, FSM state
// encodings and the quotient reported on divide-by-zero.
package seq_divider32_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam logic [DEF_WIDTH-1:0] DBZ_QUOT = '1;

endpackage

// File: rtl/seq_divider32_sub_borrow.sv
// Combinational W-bit subtract a - b formed as a + ~b + 1; borrow is the
// inverted carry out.
module seq_divider32_sub_borrow #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0] sum;

  assign sum    = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
  assign diff   = sum[W-1:0];
  assign borrow = ~sum[W];

endmodule

// File: rtl/seq_divider32.sv
// Iterative unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake, with a divide-by-zero fast path.
module seq_divider32
  import seq_divider32_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] rem_acc;
  logic [WIDTH-1:0] q_acc;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] q_nxt;

  seq_divider32_sub_borrow #(.W(WIDTH + 1)) u_sub (
    .a      ({rem_acc, q_acc[WIDTH-1]}),
    .b      ({1'b0, dvsr}),
    .diff   (trial),
    .borrow (borrow)
  );

  // trial[WIDTH] and borrow agree because the partial remainder stays below
  // the divisor, so the top difference bit is set only when the subtract wraps.
  always_comb begin
    rem_nxt = borrow ? {rem_acc[WIDTH-2:0], q_acc[WIDTH-1]} : trial[WIDTH-1:0];
    q_nxt   = {q_acc[WIDTH-2:0], ~trial[WIDTH]};
  end

  assign busy = (state != IDLE);

  // Operand and accumulator registers carry no reset; they are always
  // reloaded on an accepted start before being used.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      dvsr    <= divisor;
      rem_acc <= '0;
      q_acc   <= dividend;
    end else if (state == CALC) begin
      rem_acc <= rem_nxt;
      q_acc   <= q_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      done      <= 1'b0;
      dbz       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count <= '0;
            if (divisor == '0) begin
              state     <= DONE;
              quotient  <= DBZ_QUOT[WIDTH-1:0];
              remainder <= dividend;
              dbz       <= 1'b1;
            end else begin
              state <= CALC;
              dbz   <= 1'b0;
            end
          end
        end
        CALC: begin
          count <= count + CNT_W'(1);
          if (count == CNT_W'(WIDTH - 1)) begin
            state     <= DONE;
            quotient  <= q_nxt;
            remainder <= rem_nxt;
          end
        end
        // DONE spends one cycle with results already registered, then one
        // cycle with the done pulse, so busy covers the whole pulse.
        DONE: begin
          if (done) begin
            done  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
